mips_pc_sequencer: RTL and testbench
====================================

Name: mips_pc_sequencer

Overview:
- Owns the MIPS program counter and sequences instruction fetch through a request/acknowledge handshake with instruction memory.
- Computes the sequential address, the branch target (sign-extended immediate shifted left twice, added to PC+4) and the jump target (26-bit index shifted left twice, concatenated with PC+4[31:28]).
- Selects the next PC from these, latches the fetched instruction and presents it to decode.
- Sits between instruction memory and the control/decode stage; replaces the free-running PC register and discrete PC-source mux.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 00 internally.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- Imem_Ack  in  1  instruction memory: Imem_Rdata valid this cycle.
- Imem_Rdata  in  32  instruction word from memory.
- Stall  in  1  hazard hold from decode/hazard unit.
- Branch  in  1  current instruction is a conditional branch.
- Zero  in  1  ALU zero flag; branch taken = Branch & Zero.
- SignImm  in  32  sign-extended 16-bit branch offset, in words.
- Jump  in  1  current instruction is J/JAL.
- JumpIndex  in  26  instruction index field.
- Imem_Req  out  1  fetch request, address = PC.
- PC  out  32  current fetch address.
- PC_Plus4  out  32  PC + 4, combinational from PC.
- Instr  out  32  latched instruction.
- Instr_Valid  out  1  Instr valid for decode.
- Redirect  out  1  one-cycle pulse: PC just loaded from a branch/jump target.

Behaviour:
- Reset (RST=0, async): state=IDLE, PC=RESET_PC, Instr=0, Imem_Req=0, Instr_Valid=0, Redirect=0; PC_Plus4=RESET_PC+4.
- States: IDLE, FETCH, DECODE. Imem_Req=(state==FETCH); Instr_Valid=(state==DECODE).
- IDLE -> FETCH unconditionally on the first CLK edge after RST release.
- FETCH:
  - PC held stable while Imem_Req=1.
  - On the edge with Imem_Ack=1: Instr<=Imem_Rdata, go to DECODE.
  - Otherwise stay in FETCH; wait is unbounded.
- DECODE with Stall=1:
  - Stay in DECODE; PC and Instr unchanged; Instr_Valid held 1.
  - Branch, Jump and Zero are ignored.
- DECODE with Stall=0: on the edge, load next PC and go to FETCH. Priority:
  - Jump=1: PC<={PC_Plus4[31:28], JumpIndex, 2'b00}; Redirect=1.
  - else Branch&Zero: PC<=PC_Plus4+(SignImm<<2); Redirect=1.
  - else PC<=PC_Plus4; Redirect=0.
- Redirect is registered: high exactly the one cycle following the loading edge, otherwise 0.
- Arithmetic:
  - All 32-bit, modulo 2^32. PC 0xFFFF_FFFC + 4 wraps to 0.
  - Negative SignImm yields a backward target; SignImm<<2 discards bits [31:30].
  - PC[1:0] always 00.
- Imem_Ack in IDLE or DECODE: ignored; no state or Instr change.
- Jump and Branch&Zero both high: jump wins.
- Reset asserted mid-FETCH or mid-DECODE: immediate return to reset values. A pending memory ack after reset is ignored until FETCH is re-entered.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate Ack, then DECODE).

Test Plan:
- Reset/sequential fetch: RESET_PC=0x0040_0000, Imem_Ack tied 1, no branch/jump -> PC sequence 0x400000, 0x400004, 0x400008 on successive FETCH cycles; Imem_Req=0 during reset and first IDLE cycle.
- Branch taken backward: PC=0x0040_0010, Branch=1, Zero=1, SignImm=0xFFFF_FFFC -> next PC=0x0040_0004, Redirect=1 for one cycle. Same with Zero=0 -> PC=0x0040_0014, Redirect=0.
- Jump with priority: PC=0x1000_0008, Jump=1, Branch=1, Zero=1, JumpIndex=0x0000_100 -> PC=0x1000_0400, Redirect=1.
- Stall and memory wait:
  - Imem_Ack held 0 for 5 cycles -> PC stable, Imem_Req=1 throughout.
  - Then Stall=1 for 3 cycles in DECODE -> Instr_Valid=1, PC unchanged, Jump pulses ignored.
- Wrap and stray ack:
  - PC=0xFFFF_FFFC sequential -> PC=0x0000_0000.
  - Imem_Ack=1 while in DECODE with Imem_Rdata=0xDEAD_BEEF -> Instr unchanged.
- Async reset mid-FETCH: RST low between edges -> PC=RESET_PC and Imem_Req=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pc_sequencer                                                        |
// | MIPS program counter with fetch handshake and branch/jump next-PC select |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Rdata,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] SignImm,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  output logic        Imem_Req,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic        Redirect
);

  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_redirect;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic        w_redirect_nxt;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic        w_unused;

  // Word offset shifted into byte offset; the top two offset bits fall off.
  assign PC_Plus4        = r_pc + 32'd4;
  assign w_branch_target = PC_Plus4 + {SignImm[29:0], 2'b00};
  assign w_jump_target   = {PC_Plus4[31:28], JumpIndex, 2'b00};
  assign w_unused        = &{1'b0, SignImm[31:30]};

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_redirect_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (Imem_Ack) begin
          w_instr_nxt = Imem_Rdata;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        // A stalled instruction holds everything; control inputs are not yet valid.
        if (!Stall) begin
          w_state_nxt = FETCH;
          if (Jump) begin
            w_pc_nxt       = w_jump_target;
            w_redirect_nxt = 1'b1;
          end else if (Branch && Zero) begin
            w_pc_nxt       = w_branch_target;
            w_redirect_nxt = 1'b1;
          end else begin
            w_pc_nxt = PC_Plus4;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_pc       <= c_reset_pc;
      r_instr    <= 32'd0;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_redirect <= w_redirect_nxt;
    end
  end

  assign PC          = r_pc;
  assign Instr       = r_instr;
  assign Redirect    = r_redirect;
  assign Imem_Req    = (r_state == FETCH);
  assign Instr_Valid = (r_state == DECODE);

endmodule
`default_nettype wire

// File: tb/tb_mips_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_pc_sequencer                                                     |
// | Directed vector bench for the MIPS PC sequencer                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mips_pc_sequencer;

  localparam logic [31:0] c_reset_pc = 32'h0040_0000;
  localparam int          c_nvec     = 15;

  logic        CLK;
  logic        RST;
  logic        Imem_Ack;
  logic [31:0] Imem_Rdata;
  logic        Stall;
  logic        Branch;
  logic        Zero;
  logic [31:0] SignImm;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        Imem_Req;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic        Redirect;

  int total = 0;
  int bad   = 0;

  mips_pc_sequencer #(
    .RESET_PC(c_reset_pc)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Imem_Ack   (Imem_Ack),
    .Imem_Rdata (Imem_Rdata),
    .Stall      (Stall),
    .Branch     (Branch),
    .Zero       (Zero),
    .SignImm    (SignImm),
    .Jump       (Jump),
    .JumpIndex  (JumpIndex),
    .Imem_Req   (Imem_Req),
    .PC         (PC),
    .PC_Plus4   (PC_Plus4),
    .Instr      (Instr),
    .Instr_Valid(Instr_Valid),
    .Redirect   (Redirect)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          ack_wait;
    int          stall;
    logic [31:0] rdata;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] simm;
    logic [25:0] jidx;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        redir;
  } vec_t;

  vec_t vecs [c_nvec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int aw, input int st, input logic [31:0] rd,
                              input logic br, input logic z, input logic j,
                              input logic [31:0] si, input logic [25:0] ji,
                              input logic [31:0] pc, input logic [31:0] nx, input logic rdr);
    vec_t v;
    v.ack_wait = aw; v.stall = st; v.rdata = rd;
    v.branch = br; v.zero = z; v.jump = j; v.simm = si; v.jidx = ji;
    v.pc = pc; v.nxt = nx; v.redir = rdr;
    return v;
  endfunction

  task automatic clear_ctrl();
    Stall = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    SignImm = 32'd0; JumpIndex = 26'd0;
  endtask

  // One instruction: entered and left at a negedge with the DUT in FETCH.
  task automatic run_vec(input vec_t v);
    chk("fetch_req", {31'd0, Imem_Req}, 32'd1);
    chk("fetch_pc", PC, v.pc);
    chk("fetch_pc4", PC_Plus4, v.pc + 32'd4);
    for (int k = 0; k < v.ack_wait; k++) begin
      Imem_Ack = 1'b0;
      @(negedge CLK);
      chk("wait_req", {31'd0, Imem_Req}, 32'd1);
      chk("wait_pc", PC, v.pc);
    end
    Imem_Ack   = 1'b1;
    Imem_Rdata = v.rdata;
    @(negedge CLK);
    Imem_Ack = 1'b0;
    chk("dec_valid", {31'd0, Instr_Valid}, 32'd1);
    chk("dec_instr", Instr, v.rdata);
    chk("dec_req", {31'd0, Imem_Req}, 32'd0);
    chk("dec_redirect_low", {31'd0, Redirect}, 32'd0);
    for (int k = 0; k < v.stall; k++) begin
      Stall = 1'b1; Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
      JumpIndex = 26'h3FF_FFFF; SignImm = 32'h0000_0100;
      Imem_Ack = 1'b1; Imem_Rdata = 32'hDEAD_BEEF;
      @(negedge CLK);
      chk("stall_valid", {31'd0, Instr_Valid}, 32'd1);
      chk("stall_pc", PC, v.pc);
      chk("stall_instr", Instr, v.rdata);
    end
    Imem_Ack  = 1'b0;
    Stall     = 1'b0;
    Branch    = v.branch;
    Zero      = v.zero;
    Jump      = v.jump;
    SignImm   = v.simm;
    JumpIndex = v.jidx;
    @(negedge CLK);
    clear_ctrl();
    chk("next_pc", PC, v.nxt);
    chk("redirect", {31'd0, Redirect}, {31'd0, v.redir});
  endtask

  initial begin
    RST = 1'b0; Imem_Ack = 1'b0; Imem_Rdata = 32'd0;
    clear_ctrl();

    //           aw st rdata          br z  j  simm           jidx         pc             next           rd
    vecs[0]  = mk(0, 0, 32'h2008_0001, 0, 0, 0, 32'h0,         26'h0,       32'h0040_0000, 32'h0040_0004, 0);
    vecs[1]  = mk(0, 0, 32'h2008_0002, 0, 0, 0, 32'h0,         26'h0,       32'h0040_0004, 32'h0040_0008, 0);
    vecs[2]  = mk(5, 0, 32'h2008_0003, 0, 0, 0, 32'h0,         26'h0,       32'h0040_0008, 32'h0040_000C, 0);
    vecs[3]  = mk(0, 3, 32'h2008_0004, 0, 0, 0, 32'h0,         26'h0,       32'h0040_000C, 32'h0040_0010, 0);
    vecs[4]  = mk(0, 0, 32'h1000_FFFF, 1, 1, 0, 32'hFFFF_FFFC, 26'h0,       32'h0040_0010, 32'h0040_0004, 1);
    vecs[5]  = mk(1, 0, 32'h2008_0005, 0, 0, 0, 32'h0,         26'h0,       32'h0040_0004, 32'h0040_0008, 0);
    vecs[6]  = mk(0, 0, 32'h2008_0006, 0, 0, 0, 32'h0,         26'h0,       32'h0040_0008, 32'h0040_000C, 0);
    vecs[7]  = mk(0, 0, 32'h2008_0007, 0, 0, 0, 32'h0,         26'h0,       32'h0040_000C, 32'h0040_0010, 0);
    vecs[8]  = mk(0, 0, 32'h1000_FFFE, 1, 0, 0, 32'hFFFF_FFFC, 26'h0,       32'h0040_0010, 32'h0040_0014, 0);
    vecs[9]  = mk(0, 1, 32'h1000_0009, 1, 1, 0, 32'h03EF_FFFC, 26'h0,       32'h0040_0014, 32'h1000_0008, 1);
    vecs[10] = mk(0, 0, 32'h0800_0100, 1, 1, 1, 32'hFFFF_FFFC, 26'h000_0100, 32'h1000_0008, 32'h1000_0400, 1);
    vecs[11] = mk(2, 0, 32'h1000_000B, 1, 1, 0, 32'hFBFF_FEFE, 26'h0,       32'h1000_0400, 32'hFFFF_FFFC, 1);
    vecs[12] = mk(0, 0, 32'h2008_000C, 0, 0, 0, 32'h0,         26'h0,       32'hFFFF_FFFC, 32'h0000_0000, 0);
    vecs[13] = mk(0, 0, 32'h0BFF_FFFF, 0, 0, 1, 32'h0,         26'h3FF_FFFF, 32'h0000_0000, 32'h0FFF_FFFC, 1);
    vecs[14] = mk(0, 2, 32'h0800_0010, 0, 0, 1, 32'h0,         26'h000_0010, 32'h0FFF_FFFC, 32'h1000_0040, 1);

    // Reset values, held across a clock edge.
    @(negedge CLK);
    chk("rst_pc", PC, c_reset_pc);
    chk("rst_pc4", PC_Plus4, c_reset_pc + 32'd4);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_req", {31'd0, Imem_Req}, 32'd0);
    chk("rst_valid", {31'd0, Instr_Valid}, 32'd0);
    chk("rst_redirect", {31'd0, Redirect}, 32'd0);
    RST = 1'b1;
    #2;
    chk("idle_req", {31'd0, Imem_Req}, 32'd0);
    chk("idle_valid", {31'd0, Instr_Valid}, 32'd0);
    @(negedge CLK);

    for (int i = 0; i < c_nvec; i++) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset between edges while fetching.
    Imem_Ack = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    chk("arst_pc", PC, c_reset_pc);
    chk("arst_req", {31'd0, Imem_Req}, 32'd0);
    chk("arst_instr", Instr, 32'd0);
    chk("arst_valid", {31'd0, Instr_Valid}, 32'd0);

    // An ack held across reset release must be ignored in IDLE.
    Imem_Ack   = 1'b1;
    Imem_Rdata = 32'hCAFE_0001;
    @(negedge CLK);
    RST = 1'b1;
    #2;
    chk("post_idle_req", {31'd0, Imem_Req}, 32'd0);
    @(negedge CLK);
    chk("post_fetch_req", {31'd0, Imem_Req}, 32'd1);
    chk("post_fetch_instr", Instr, 32'd0);
    chk("post_fetch_pc", PC, c_reset_pc);
    @(negedge CLK);
    Imem_Ack = 1'b0;
    chk("post_dec_instr", Instr, 32'hCAFE_0001);
    chk("post_dec_valid", {31'd0, Instr_Valid}, 32'd1);
    @(negedge CLK);
    chk("post_next_pc", PC, c_reset_pc + 32'd4);
    chk("post_redirect", {31'd0, Redirect}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
